// File: rtl/vector_line_stepper.sv
// Bresenham line stepper feeding a two-channel DAC driver: one X write then one Y write per unit step.
// Latency: busy 1 cycle after accept; first strobe >=2 cycles later; strobes are >=2 cycles apart.
// Backpressure: stalls in EMIT_X/EMIT_Y while dac_ready=0; cmd_ready only in IDLE. Option: VECTOR_BLANK_JUMP_EN.
module vector_line_stepper #(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic             cmd_blank,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] dac_value,
    output logic             dac_axis,
    output logic             dac_strobe,
    input  logic             dac_ready,
    output logic             beam_on,
    output logic             busy,
    output logic [WIDTH-1:0] pos_x,
    output logic [WIDTH-1:0] pos_y
);
    localparam int EW = WIDTH + 2;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_STEP, S_EMIT_X, S_WAIT_X, S_EMIT_Y, S_WAIT_Y, S_SETTLE
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0]    cx, cy, tx, ty;
    logic signed [EW-1:0] dx, dy, err, err_step, dx_new, dy_new;
    logic signed [EW:0]   e2, dy_ext, dx_ext;
    logic [WIDTH-1:0]    adx, ady;
    logic                sx, sy, step_x, step_y;
    logic                accept, at_target, cmd_jump, strobe_q;
    logic [SW-1:0]       settle_cnt;

`ifdef VECTOR_BLANK_JUMP_EN
    logic blank_q;
    assign cmd_jump = cmd_blank;
    assign beam_on  = busy && !blank_q;
`else
    logic unused_blank;
    assign unused_blank = cmd_blank;
    assign cmd_jump     = 1'b0;
    assign beam_on      = busy;
`endif

    assign busy       = (state != S_IDLE);
    assign cmd_ready  = reset && (state == S_IDLE);
    // Gated so that a reset cycle never shows a write to the driver.
    assign dac_strobe = strobe_q && reset;
    assign accept     = cmd_valid && cmd_ready;
    assign at_target  = (cx == tx) && (cy == ty);

    assign adx    = (cmd_x >= cx) ? cmd_x - cx : cx - cmd_x;
    assign ady    = (cmd_y >= cy) ? cmd_y - cy : cy - cmd_y;
    assign dx_new = $signed({2'b00, adx});
    assign dy_new = -$signed({2'b00, ady});

    assign e2       = {err, 1'b0};
    assign dy_ext   = {dy[EW-1], dy};
    assign dx_ext   = {dx[EW-1], dx};
    assign step_x   = (e2 >= dy_ext);
    assign step_y   = (e2 <= dx_ext);
    assign err_step = err + (step_x ? dy : '0) + (step_y ? dx : '0);

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_jump || ((cmd_x == cx) && (cmd_y == cy)))
                        state_d = S_EMIT_X;
                    else
                        state_d = S_STEP;
                end
            end
            S_STEP:   state_d = S_EMIT_X;
            S_EMIT_X: if (dac_ready) state_d = S_WAIT_X;
            S_WAIT_X: state_d = S_EMIT_Y;
            S_EMIT_Y: if (dac_ready) state_d = S_WAIT_Y;
            S_WAIT_Y: begin
                if (SETTLE > 0)
                    state_d = S_SETTLE;
                else
                    state_d = at_target ? S_IDLE : S_STEP;
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST)
                    state_d = at_target ? S_IDLE : S_STEP;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            tx         <= '0;
            ty         <= '0;
            dx         <= '0;
            dy         <= '0;
            err        <= '0;
            sx         <= 1'b0;
            sy         <= 1'b0;
            dac_value  <= '0;
            dac_axis   <= 1'b0;
            strobe_q   <= 1'b0;
            pos_x      <= '0;
            pos_y      <= '0;
            settle_cnt <= '0;
`ifdef VECTOR_BLANK_JUMP_EN
            blank_q    <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            strobe_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tx  <= cmd_x;
                        ty  <= cmd_y;
                        dx  <= dx_new;
                        dy  <= dy_new;
                        err <= dx_new + dy_new;
                        sx  <= (cmd_x >= cx);
                        sy  <= (cmd_y >= cy);
`ifdef VECTOR_BLANK_JUMP_EN
                        blank_q <= cmd_blank;
                        if (cmd_blank) begin
                            cx <= cmd_x;
                            cy <= cmd_y;
                        end
`endif
                    end
                end
                S_STEP: begin
                    err <= err_step;
                    if (step_x) cx <= sx ? cx + WIDTH'(1) : cx - WIDTH'(1);
                    if (step_y) cy <= sy ? cy + WIDTH'(1) : cy - WIDTH'(1);
                end
                S_EMIT_X: begin
                    if (dac_ready) begin
                        strobe_q  <= 1'b1;
                        dac_value <= cx;
                        dac_axis  <= 1'b0;
                        pos_x     <= cx;
                    end
                end
                S_EMIT_Y: begin
                    if (dac_ready) begin
                        strobe_q  <= 1'b1;
                        dac_value <= cy;
                        dac_axis  <= 1'b1;
                        pos_y     <= cy;
                    end
                end
                S_WAIT_Y: settle_cnt <= '0;
                S_SETTLE: settle_cnt <= settle_cnt + SW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_line_stepper.sv
// Directed bench for vector_line_stepper: expected DAC writes are queued at stimulus time and
// popped by a strobe monitor; a simple driver model drops dac_ready the cycle after each strobe.
module tb_vector_line_stepper;
    localparam int W = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] cmd_x, cmd_y;
    logic         cmd_blank, cmd_valid, cmd_ready;
    logic [W-1:0] dac_value;
    logic         dac_axis, dac_strobe, dac_ready;
    logic         beam_on, busy;
    logic [W-1:0] pos_x, pos_y;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           nstrobe = 0;
    int           last_sc = -100;
    logic [12:0]  exp_q[$];
    logic         hold = 1'b0;
    logic         last_strobe = 1'b0;
    logic         exp_blank = 1'b0;
    logic         started = 1'b0;
    int           mx = 0;
    int           my = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    vector_line_stepper #(.WIDTH(W), .SETTLE(0)) dut (
        .clk(clk), .reset(reset), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_blank(cmd_blank),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .dac_value(dac_value),
        .dac_axis(dac_axis), .dac_strobe(dac_strobe), .dac_ready(dac_ready),
        .beam_on(beam_on), .busy(busy), .pos_x(pos_x), .pos_y(pos_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int v, input logic a);
        logic [W-1:0] vv;
        vv = W'(v);
        exp_q.push_back({a, vv});
    endtask

    // Textbook Bresenham from the bench's own position model; start point is not emitted.
    task automatic model_line(input int tx, input int ty);
        int dx, dy, sx, sy, err, e2;
        dx = (tx >= mx) ? tx - mx : mx - tx;
        dy = (ty >= my) ? my - ty : ty - my;
        sx = (tx >= mx) ? 1 : -1;
        sy = (ty >= my) ? 1 : -1;
        err = dx + dy;
        if (tx == mx && ty == my) begin
            push(mx, 1'b0);
            push(my, 1'b1);
        end
        while (!(mx == tx && my == ty)) begin
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; mx += sx; end
            if (e2 <= dx) begin err += dx; my += sy; end
            push(mx, 1'b0);
            push(my, 1'b1);
        end
    endtask

    task automatic monitor();
        logic [12:0] e;
        forever begin
            @(negedge clk);
            last_strobe = (dac_strobe === 1'b1);
            if (started && reset === 1'b1)
                chk("beam_on", beam_on, busy && !exp_blank);
            if (dac_strobe === 1'b1) begin
                nstrobe++;
                if (last_sc >= 0) chk("strobe_gap_ge2", (cyc - last_sc) >= 2, 1);
                last_sc = cyc;
                chk("strobe_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("strobe_axis_value", {dac_axis, dac_value}, e);
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            dac_ready = !hold && !last_strobe;
        end
    endtask

    task automatic send(input int x, input int y, input logic b);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #2; n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_x = W'(x); cmd_y = W'(y); cmd_blank = b; cmd_valid = 1'b1;
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20000) begin
            @(posedge clk); #2; n++;
        end
        chk("idle_wait", busy, 0);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_strobes(input int n0, input int k);
        int n;
        n = 0;
        while ((nstrobe - n0) < k && n < 5000) begin
            @(posedge clk); #2; n++;
        end
        chk("strobe_wait", (nstrobe - n0) >= k, 1);
    endtask

    initial begin
        int n0;
        int n1;
        logic [W-1:0] v;
        reset = 1'b0; cmd_valid = 1'b1; cmd_x = 12'd7; cmd_y = 12'd7; cmd_blank = 1'b0;
        dac_ready = 1'b1;
        fork
            monitor();
            ready_driver();
        join_none

        // Reset held 3 cycles with a command pending.
        repeat (3) begin
            @(posedge clk); #2;
            started = 1'b1;
            chk("rst_strobe", dac_strobe, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_pos", {pos_x, pos_y}, 0);
        end
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #2;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);

        // (0,0) -> (3,0)
        n0 = nstrobe;
        push(1, 1'b0); push(0, 1'b1); push(2, 1'b0); push(0, 1'b1); push(3, 1'b0); push(0, 1'b1);
        mx = 3; my = 0;
        send(3, 0, 1'b0);
        wait_idle();
        chk("line_a_count", nstrobe - n0, 6);
        chk("line_a_pos", {pos_x, pos_y}, {12'd3, 12'd0});

        // (3,0) -> (0,3): diagonal
        n0 = nstrobe;
        push(2, 1'b0); push(1, 1'b1); push(1, 1'b0); push(2, 1'b1); push(0, 1'b0); push(3, 1'b1);
        mx = 0; my = 3;
        send(0, 3, 1'b0);
        wait_idle();
        chk("line_b_count", nstrobe - n0, 6);
        chk("line_b_pos", {pos_x, pos_y}, {12'd0, 12'd3});

        // Move to (5,5), then zero-length refresh.
        model_line(5, 5);
        send(5, 5, 1'b0);
        wait_idle();
        n0 = nstrobe;
        model_line(5, 5);
        send(5, 5, 1'b0);
        wait_idle();
        chk("zero_len_count", nstrobe - n0, 2);
        chk("zero_len_ready", cmd_ready, 1);

        // Backpressure mid-line: dac_ready low for 20 cycles.
        n0 = nstrobe;
        model_line(15, 9);
        send(15, 9, 1'b0);
        wait_strobes(n0, 5);
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        v = dac_value;
        n1 = nstrobe;
        repeat (18) begin
            @(posedge clk); #2;
            chk("bp_no_strobe", dac_strobe, 0);
            chk("bp_value_stable", dac_value, v);
        end
        @(posedge clk);
        hold = 1'b0;
        #2;
        chk("bp_count_frozen", nstrobe, n1);
        chk("bp_no_strobe_yet", dac_strobe, 0);
        @(posedge clk); #2;
        chk("bp_resume", dac_strobe, 1);
        wait_idle();
        chk("bp_count", nstrobe - n0, 20);
        chk("bp_pos", {pos_x, pos_y}, {12'd15, 12'd9});

        // Reset after the 3rd strobe of a 10-point line.
        n0 = nstrobe;
        model_line(5, 9);
        send(5, 9, 1'b0);
        wait_strobes(n0, 3);
        reset = 1'b0;
        chk("abort_rst_cycle_strobe", dac_strobe, 0);
        @(posedge clk); #2;
        chk("abort_busy", busy, 0);
        chk("abort_cmd_ready", cmd_ready, 0);
        chk("abort_pos", {pos_x, pos_y}, 0);
        reset = 1'b1;
        exp_q.delete();
        mx = 0; my = 0;
        n1 = nstrobe;
        repeat (40) @(posedge clk);
        #2;
        chk("abort_no_more_strobes", nstrobe, n1);
        chk("abort_idle_ready", cmd_ready, 1);

`ifdef VECTOR_BLANK_JUMP_EN
        // Blank jump: single endpoint, beam off.
        n0 = nstrobe;
        exp_blank = 1'b1;
        push(100, 1'b0); push(200, 1'b1);
        mx = 100; my = 200;
        send(100, 200, 1'b1);
        wait_idle();
        exp_blank = 1'b0;
        chk("blank_count", nstrobe - n0, 2);
        chk("blank_pos", {pos_x, pos_y}, {12'd100, 12'd200});
`endif

        // Normal line after the abort, from (0,0).
        n0 = nstrobe;
        model_line(mx + 4, my + 7);
        send(mx, my, 1'b0);
        wait_idle();
        chk("final_count", nstrobe - n0, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
